rca_seq_ctrl: RTL and testbench



---
 rtl/rca_pkg.sv | 20 ++
 rtl/rca_slice.sv | 23 ++
 rtl/rca_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_rca_seq_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared types and defaults for the multi-precision add sequencer.
package rca_pkg;

    localparam int RCA_N_DEFAULT      = 4;
    localparam int RCA_CHUNKS_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rca_state_t;

    // Chunk index width; a single-chunk build still needs a 1-bit counter.
    function automatic int idx_width(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

    localparam int RCA_IDX_W_DEFAULT = idx_width(RCA_CHUNKS_DEFAULT);

endpackage

// File: rtl/rca_slice.sv
// N-bit combinational ripple-carry adder slice with carry-in and carry-out.
module rca_slice #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);

    always_comb begin
        logic w_c;
        w_c   = i_cin;
        o_sum = '0;
        for (int i = 0; i < N; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
            w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_c;
    end

endmodule

// File: rtl/rca_seq_ctrl.sv
// Multi-precision add sequencer: one shared N-bit slice walks CHUNKS chunks, LSB first.
// Define RCA_SEQ_SUB_EN to add the 'sub' port (a-b via inverted B and carry-in 1).
module rca_seq_ctrl
    import rca_pkg::*;
#(
    parameter int N      = RCA_N_DEFAULT,
    parameter int CHUNKS = RCA_CHUNKS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*CHUNKS-1:0] a,
    input  logic [N*CHUNKS-1:0] b,
`ifdef RCA_SEQ_SUB_EN
    input  logic                sub,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*CHUNKS:0]   sum,
    output logic                busy
);

    localparam int W     = N * CHUNKS;
    localparam int IDX_W = idx_width(CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    rca_state_t       r_state;
    rca_state_t       w_state_next;
    logic             w_accept;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W:0]       r_sum;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [N-1:0]     w_a_sel;
    logic [N-1:0]     w_b_sel;
    logic [N-1:0]     w_b_op;
    logic [N-1:0]     w_slice_sum;
    logic             w_slice_cout;
    logic             w_carry_init;

`ifdef RCA_SEQ_SUB_EN
    logic r_sub;
    assign w_b_op       = w_b_sel ^ {N{r_sub}};
    assign w_carry_init = sub;
`else
    assign w_b_op       = w_b_sel;
    assign w_carry_init = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // in_ready only rises once DONE has been left, so the two never overlap.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_a_sel = '0;
        w_b_sel = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            if (int'(r_idx) == i) begin
                w_a_sel = r_a[i*N +: N];
                w_b_sel = r_b[i*N +: N];
            end
        end
    end

    rca_slice #(
        .N(N)
    ) u_slice (
        .i_a    (w_a_sel),
        .i_b    (w_b_op),
        .i_cin  (r_carry),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
`ifdef RCA_SEQ_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_idx   <= '0;
            r_carry <= w_carry_init;
`ifdef RCA_SEQ_SUB_EN
            r_sub   <= sub;
`endif
        end else if (r_state == RUN) begin
            for (int i = 0; i < CHUNKS; i++) begin
                if (int'(r_idx) == i) begin
                    r_sum[i*N +: N] <= w_slice_sum;
                end
            end
            r_carry <= w_slice_cout;
            if (r_idx == LAST_IDX) begin
                r_sum[W] <= w_slice_cout;
                r_idx    <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign sum = r_sum;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Scoreboard bench for rca_seq_ctrl (N=4,CHUNKS=4) plus a single-chunk N=8 instance.
module tb_rca_seq_ctrl;

    localparam int N  = 4;
    localparam int CH = 4;
    localparam int W  = N * CH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0]  a, b;
    logic [W:0]    sum;
`ifdef RCA_SEQ_SUB_EN
    logic          sub;
    logic          sub1;
`endif

    logic          in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [7:0]    a1, b1;
    logic [8:0]    sum1;

    rca_seq_ctrl #(.N(N), .CHUNKS(CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef RCA_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .busy      (busy)
    );

    rca_seq_ctrl #(.N(8), .CHUNKS(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
`ifdef RCA_SEQ_SUB_EN
        .sub       (sub1),
`endif
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .busy      (busy1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: unsigned add, or a-b as a + 2^W - b (top bit = no borrow).
    function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        longint r;
        if (s) r = longint'(x) + (longint'(1) << W) - longint'(y);
        else   r = longint'(x) + longint'(y);
        return r[W:0];
    endfunction

    typedef struct {
        logic [W:0] s;
        int         acc;
    } exp_t;

    exp_t q[$];

    // Monitor: compares every handshaken result against the scoreboard head.
    logic prev_ov  = 1'b0;
    int   rise_cyc = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) rise_cyc = cyc;
            prev_ov = out_valid;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sum", 32'(sum), 32'(e.s));
                    chk("latency", 32'(rise_cyc - e.acc), 32'(CH + 1));
                    chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
                    $display("txn: acc_cyc=%0d sum=0x%05h exp=0x%05h", e.acc, sum, e.s);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int   waited;
        exp_t e;
        waited   = 0;
        in_valid = 1'b1;
        a        = x;
        b        = y;
`ifdef RCA_SEQ_SUB_EN
        sub      = s;
`endif
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("send_accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        e.s   = ref_sum(x, y, s);
        e.acc = cyc;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] x, y;
        logic [W:0]   expv;
        logic         s;
        int           k, acc1;
        logic [7:0]   p, r;

        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        a1         = '0;
        b1         = '0;
        out_ready1 = 1'b1;
`ifdef RCA_SEQ_SUB_EN
        sub        = 1'b0;
        sub1       = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_busy",      {31'd0, busy},      32'd0);
        chk("reset_sum",       32'(sum),           32'd0);
        chk("reset_in_ready1", {31'd0, in_ready1}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full carry ripple, then no-carry pattern.
        send(16'hFFFF, 16'h0001, 1'b0);
        send(16'h1234, 16'h4321, 1'b0);
        wait_drain();

        // Backpressure: result held; a pending request is not taken.
        out_ready = 1'b0;
        send(16'hABCD, 16'h1111, 1'b0);
        expv = ref_sum(16'hABCD, 16'h1111, 1'b0);
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("bp_out_valid_seen", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b1;
        a        = 16'h0F0F;
        b        = 16'h00F1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_sum",       32'(sum),           32'(expv));
            chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
            chk("bp_busy",      {31'd0, busy},      32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'h0F0F, 16'h00F1, 1'b0);
        wait_drain();

        // Reset in the second RUN cycle discards the operation.
        send(16'hFFFF, 16'hFFFF, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_busy",      {31'd0, busy},      32'd0);
        chk("midrst_sum",       32'(sum),           32'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("midrst_no_out_valid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        send(16'h0003, 16'h0004, 1'b0);
        wait_drain();

`ifdef RCA_SEQ_SUB_EN
        send(16'h0005, 16'h0007, 1'b1);
        send(16'h0007, 16'h0005, 1'b1);
        wait_drain();
`endif

        // Randomised traffic with occasional idle gaps.
        for (int i = 0; i < 200; i++) begin
            x = W'($urandom);
            y = W'($urandom);
`ifdef RCA_SEQ_SUB_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send(x, y, s);
        end
        wait_drain();

        // Single-chunk instance: fixed boundary case then a few random pairs.
        for (int i = 0; i < 4; i++) begin
            p = (i == 0) ? 8'hFF : 8'($urandom);
            r = (i == 0) ? 8'hFF : 8'($urandom);
            in_valid1 = 1'b1;
            a1        = p;
            b1        = r;
            @(negedge clk);
            k = 0;
            while (!in_ready1 && k < 20) begin
                @(negedge clk);
                k++;
            end
            acc1 = cyc;
            @(posedge clk);
            #1;
            in_valid1 = 1'b0;
            k = 0;
            @(negedge clk);
            while (!out_valid1 && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("c1_latency", 32'(cyc - acc1), 32'd2);
            chk("c1_sum",     32'(sum1),       32'(int'(p) + int'(r)));
            $display("txn c1: a=0x%02h b=0x%02h sum=0x%03h", p, r, sum1);
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
